ccff_chain_loader: RTL and testbench

- Upstream stage of fpga_top. Accepts the bitstream as a valid/ready stream of column words, one bit per configuration chain, and shifts them into the parallel ccff_head chains.
- After the last shift it holds the fabric in reset for a settle window, then releases global_resetn toward the fabric and flags completion.
- Replaces the text-file bitstream force used in the formal benches with a synthesizable loader that the bitstream benches drive directly.

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_sat_counter.sv | 22 ++
 rtl/ccff_chain_loader.sv | 130 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration chain loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int NUM_CHAINS_DFLT = 10;
    localparam int SETTLE_DFLT     = 8;

endpackage

// File: rtl/ccff_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module ccff_sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams column words into parallel ccff chains, then releases the fabric
// reset after a settle window.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS    = NUM_CHAINS_DFLT,
    parameter int CHAIN_LEN     = 4096,
    parameter int SETTLE_CYCLES = SETTLE_DFLT,
    parameter int STALL_MAX     = 255,
    parameter int CNT_W         = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clock,
    input  logic                  global_resetn,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [NUM_CHAINS-1:0] in_data,
    output logic                  in_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  ccff_shift_en,
    output logic                  fabric_resetn,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [NUM_CHAINS-1:0] tail_last
);

    localparam int STALL_W  = $clog2(STALL_MAX + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]    SHIFT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(STALL_MAX - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e state, state_n;

    logic                shift_clr;
    logic                stall_clr;
    logic                accept;
    logic                last_shift_q;
    logic [CNT_W-1:0]    shift_cnt;
    logic [STALL_W-1:0]  stall_cnt;
    logic [SETTLE_W-1:0] settle_cnt;

    assign in_ready = (state == ST_LOAD);
    assign accept   = in_ready && in_valid;
    assign busy     = (state == ST_LOAD) || (state == ST_SETTLE);
    assign cfg_done = (state == ST_DONE);
    assign cfg_err  = (state == ST_ERR);

    ccff_sat_counter #(.W(CNT_W), .MAX(CNT_W'(CHAIN_LEN))) u_shift_cnt (
        .clk   (prog_clock),
        .rst_n (global_resetn),
        .clr   (shift_clr),
        .en    (accept),
        .cnt   (shift_cnt)
    );

    ccff_sat_counter #(.W(STALL_W), .MAX(STALL_W'(STALL_MAX))) u_stall_cnt (
        .clk   (prog_clock),
        .rst_n (global_resetn),
        .clr   (stall_clr),
        .en    ((state == ST_LOAD) && !in_valid),
        .cnt   (stall_cnt)
    );

    ccff_sat_counter #(.W(SETTLE_W), .MAX(SETTLE_W'(SETTLE_CYCLES))) u_settle_cnt (
        .clk   (prog_clock),
        .rst_n (global_resetn),
        .clr   (state != ST_SETTLE),
        .en    (state == ST_SETTLE),
        .cnt   (settle_cnt)
    );

    always_ff @(posedge prog_clock or negedge global_resetn) begin
        if (!global_resetn)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        shift_clr = 1'b0;
        stall_clr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n   = ST_LOAD;
                    shift_clr = 1'b1;
                    stall_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    stall_clr = 1'b1;
                    if (shift_cnt == SHIFT_LAST)
                        state_n = ST_SETTLE;
                end else if (stall_cnt == STALL_LAST) begin
                    state_n = ST_ERR;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // fabric_resetn is a flop so the fabric never sees decode glitches.
    always_ff @(posedge prog_clock or negedge global_resetn) begin
        if (!global_resetn) begin
            ccff_head     <= '0;
            ccff_shift_en <= 1'b0;
            last_shift_q  <= 1'b0;
            tail_last     <= '0;
            fabric_resetn <= 1'b0;
        end else begin
            ccff_shift_en <= accept;
            last_shift_q  <= accept && (shift_cnt == SHIFT_LAST);
            fabric_resetn <= (state_n == ST_DONE);
            if (accept)
                ccff_head <= in_data;
            if (last_shift_q)
                tail_last <= ccff_tail;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural chain model and a
// head-word scoreboard.
module tb_ccff_chain_loader;

    localparam int NC = 10;
    localparam int CL = 4;
    localparam int SC = 8;
    localparam int SM = 5;

    logic          prog_clock;
    logic          global_resetn;
    logic          start;
    logic          in_valid;
    logic [NC-1:0] in_data;
    logic          in_ready;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          ccff_shift_en;
    logic          fabric_resetn;
    logic          busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [NC-1:0] tail_last;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int shifts = 0;
    int last_shift_cyc = -1;
    int rise_cyc = -1;
    logic fab_prev = 1'b0;
    logic [NC-1:0] sb[$];
    logic [CL-1:0][NC-1:0] chain = '0;

    ccff_chain_loader #(
        .NUM_CHAINS(NC), .CHAIN_LEN(CL), .SETTLE_CYCLES(SC), .STALL_MAX(SM)
    ) dut (
        .prog_clock    (prog_clock),
        .global_resetn (global_resetn),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .fabric_resetn (fabric_resetn),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .tail_last     (tail_last)
    );

    initial begin
        prog_clock = 1'b0;
        forever #5 prog_clock = ~prog_clock;
    end

    // Fabric chains: keep their contents across loader resets.
    always @(posedge prog_clock)
        if (ccff_shift_en)
            chain <= {chain[CL-2:0], ccff_head};
    assign ccff_tail = chain[CL-1];

    always @(posedge prog_clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge prog_clock) begin
        if (!global_resetn) begin
            sb.delete();
        end else begin
            if (ccff_shift_en) begin
                shifts++;
                last_shift_cyc = cyc;
                if (sb.size() == 0)
                    chk("sb_underflow", 32'd1, 32'd0);
                else
                    chk("head_word", 32'(ccff_head), 32'(sb.pop_front()));
            end
            if (fabric_resetn && !fab_prev)
                rise_cyc = cyc;
            if (in_valid && in_ready)
                sb.push_back(in_data);
        end
        fab_prev = fabric_resetn;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge prog_clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_head"}, 32'(ccff_head), 32'd0);
        chk({tag, "_shen"}, 32'(ccff_shift_en), 32'd0);
        chk({tag, "_fab"}, 32'(fabric_resetn), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_tail"}, 32'(tail_last), 32'd0);
    endtask

    // Full load; in_valid is already high in the start cycle to show that
    // nothing is taken before LOAD.
    task automatic do_load(input logic [CL-1:0][NC-1:0] w, input bit gap,
                           input bit chk_tail, input logic [NC-1:0] exp_tail);
        int n;
        shifts = 0;
        last_shift_cyc = -1;
        rise_cyc = -1;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = w[0];
        tick();
        start = 1'b0;
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_fab_low", 32'(fabric_resetn), 32'd0);
        chk("ld_done_clr", 32'(cfg_done), 32'd0);
        chk("ld_ready", 32'(in_ready), 32'd1);
        chk("ld_no_early_shift", 32'(ccff_shift_en), 32'd0);
        for (int i = 0; i < CL; i++) begin
            in_valid = 1'b1;
            in_data = w[i];
            tick();
            if (i == CL - 1)
                chk("ready_drop", 32'(in_ready), 32'd0);
            if (gap && i < CL - 1) begin
                in_valid = 1'b0;
                in_data = ~w[i];
                tick();
                chk("gap_hold", 32'(ccff_head), 32'(w[i]));
                chk("gap_shen", 32'(ccff_shift_en), 32'd0);
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (!cfg_done && n < 50) begin
            tick();
            n++;
        end
        @(negedge prog_clock);
        #1;
        chk("done_timeout", 32'(n < 50), 32'd1);
        chk("cfg_done", 32'(cfg_done), 32'd1);
        chk("fab_high", 32'(fabric_resetn), 32'd1);
        chk("no_err", 32'(cfg_err), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("shift_count", 32'(shifts), 32'(CL));
        chk("settle_gap", 32'(rise_cyc - last_shift_cyc), 32'(SC));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        if (chk_tail)
            chk("tail_last", 32'(tail_last), 32'(exp_tail));
    endtask

    initial begin
        logic [CL-1:0][NC-1:0] wa;
        logic [CL-1:0][NC-1:0] wb;
        logic [CL-1:0][NC-1:0] wc;
        wa = {10'h2AA, 10'h155, 10'h000, 10'h3FF};
        wb = {10'h0C3, 10'h3F0, 10'h21E, 10'h0F1};
        wc = {10'h001, 10'h3FE, 10'h0AB, 10'h123};

        global_resetn = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) tick();
        chk_reset_vals("rst");
        global_resetn = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Continuous stream from IDLE; chains start at zero.
        do_load(wa, 1'b0, 1'b1, '0);
        // Same words with bubbles, restarted from DONE.
        do_load(wa, 1'b1, 1'b1, 10'h2AA);

        // Stall timeout after two words.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = wb[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (SM - 1) tick();
        chk("stall_no_err_yet", 32'(cfg_err), 32'd0);
        chk("stall_ready", 32'(in_ready), 32'd1);
        tick();
        chk("stall_err", 32'(cfg_err), 32'd1);
        chk("stall_ready_low", 32'(in_ready), 32'd0);
        chk("stall_fab_low", 32'(fabric_resetn), 32'd0);
        chk("stall_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_data = wb[2];
        tick();
        chk("err_no_shift", 32'(ccff_shift_en), 32'd0);
        chk("err_held", 32'(cfg_err), 32'd1);
        in_valid = 1'b0;

        // Restart from ERR, then reset during the third word.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = wb[i];
            tick();
        end
        #2;
        global_resetn = 1'b0;
        #1;
        chk_reset_vals("async");
        in_valid = 1'b0;
        tick();
        global_resetn = 1'b1;
        tick();
        do_load(wb, 1'b0, 1'b0, '0);

        // Reload from DONE; the final shift pushes out the previous last word.
        do_load(wc, 1'b0, 1'b1, wb[CL-1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
